// File: rtl/demod_segment_frame_ctrl.sv
// Deserialises WIDTH-bit demodulated words into NUM_SEG-segment frames.
// A collect buffer fills while the previous frame is held on a valid/ready output.
module demod_segment_frame_ctrl #(
  parameter int WIDTH   = 32,
  parameter int NUM_SEG = 10,
  localparam int CNT_W  = $clog2(NUM_SEG + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         input_bit,
  output logic                     in_ready,
  output logic [NUM_SEG*WIDTH-1:0] segments_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         word_count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SEG);

  logic [CNT_W-1:0]         word_count_reg;
  logic [NUM_SEG*WIDTH-1:0] segments_reg;
  logic                     out_valid_reg;
  logic [NUM_SEG*WIDTH-1:0] collect_flat;

  logic full;
  logic accept;
  logic transfer;
  logic abort;

  assign full     = (word_count_reg == FULL_CNT);
  assign in_ready = start && (word_count_reg < FULL_CNT);
  assign accept   = in_valid && in_ready;
  assign transfer = full && (!out_valid_reg || out_ready);
  // A full frame is never aborted; only a partially filled one is dropped.
  assign abort    = !start && !full && (word_count_reg != '0);

  for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
    logic [WIDTH-1:0] seg_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        seg_reg <= '0;
      end else if (accept && (word_count_reg == CNT_W'(gi))) begin
        seg_reg <= input_bit;
      end
    end

    assign collect_flat[gi*WIDTH +: WIDTH] = seg_reg;
  end

  // Transfer and consume on the same edge keep out_valid high: no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count_reg <= '0;
      out_valid_reg  <= 1'b0;
      segments_reg   <= '0;
    end else begin
      if (transfer) begin
        segments_reg   <= collect_flat;
        out_valid_reg  <= 1'b1;
        word_count_reg <= '0;
      end else begin
        if (out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
        end
        if (accept) begin
          word_count_reg <= word_count_reg + CNT_W'(1);
        end else if (abort) begin
          word_count_reg <= '0;
        end
      end
    end
  end

  assign segments_out = segments_reg;
  assign out_valid    = out_valid_reg;
  assign word_count   = word_count_reg;
  assign busy         = (word_count_reg != '0) || out_valid_reg;

endmodule

// File: tb/tb_demod_segment_frame_ctrl.sv
// Randomised and directed bench for demod_segment_frame_ctrl with a queue-based
// reference model; a second instance exercises the single-segment case.
module tb_demod_segment_frame_ctrl;

  localparam int WIDTH   = 32;
  localparam int NUM_SEG = 10;
  localparam int CNT_W   = $clog2(NUM_SEG + 1);
  localparam int FW      = NUM_SEG * WIDTH;

  logic clk = 1'b0;
  logic reset;
  logic start, in_valid, out_ready;
  logic [WIDTH-1:0] input_bit;
  logic in_ready, out_valid, busy;
  logic [FW-1:0] segments_out;
  logic [CNT_W-1:0] word_count;

  logic start1, in_valid1, out_ready1;
  logic [WIDTH-1:0] input_bit1;
  logic in_ready1, out_valid1, busy1;
  logic [WIDTH-1:0] segments_out1;
  logic [0:0] word_count1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  demod_segment_frame_ctrl #(.WIDTH(WIDTH), .NUM_SEG(NUM_SEG)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .input_bit(input_bit), .in_ready(in_ready), .segments_out(segments_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .word_count(word_count)
  );

  demod_segment_frame_ctrl #(.WIDTH(WIDTH), .NUM_SEG(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1),
    .input_bit(input_bit1), .in_ready(in_ready1), .segments_out(segments_out1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1),
    .word_count(word_count1)
  );

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: words of the frame being collected, frames awaiting
  // consumption in completion order, and whether the output is occupied.
  logic [WIDTH-1:0] cur_q[$];
  logic [FW-1:0]    exp_q[$];
  bit               m_ov = 1'b0;
  int               frames_done = 0;
  int               frames_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      cur_q.delete();
      exp_q.delete();
      m_ov = 1'b0;
    end else begin
      bit full, xfer, acc;
      logic [FW-1:0] f;
      chk("in_ready", FW'(in_ready), FW'(start && (cur_q.size() < NUM_SEG)));
      chk("word_count", FW'(word_count), FW'(cur_q.size()));
      chk("out_valid", FW'(out_valid), FW'(m_ov));
      chk("busy", FW'(busy), FW'((cur_q.size() != 0) || m_ov));
      full = (cur_q.size() == NUM_SEG);
      xfer = full && (!m_ov || out_ready);
      acc  = in_valid && start && (cur_q.size() < NUM_SEG);
      if (xfer) begin
        m_ov = 1'b1;
        cur_q.delete();
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (acc) begin
        cur_q.push_back(input_bit);
        if (cur_q.size() == NUM_SEG) begin
          f = '0;
          for (int k = 0; k < NUM_SEG; k++) f[k*WIDTH +: WIDTH] = cur_q[k];
          exp_q.push_back(f);
          frames_done++;
        end
      end else if (!start && (cur_q.size() > 0) && (cur_q.size() < NUM_SEG)) begin
        cur_q.delete();
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  bit            prev_held = 1'b0;
  logic [FW-1:0] prev_seg;

  always @(negedge clk) begin
    if (reset) begin
      prev_held = 1'b0;
    end else begin
      if (prev_held && out_valid) chk("held_stable", segments_out, prev_seg);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", FW'(1), FW'(0));
        end else begin
          chk("frame_data", segments_out, exp_q.pop_front());
          frames_seen++;
          $display("frame %0d consumed seg0=%h seg9=%h", frames_seen,
                   segments_out[WIDTH-1:0], segments_out[FW-1 -: WIDTH]);
        end
      end
      prev_held = out_valid && !out_ready;
      prev_seg  = segments_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    int n = 0;
    in_valid  = 1'b1;
    input_bit = w;
    while (!in_ready && n < 60) begin
      step();
      n++;
    end
    if (!in_ready) chk("send_timeout", FW'(0), FW'(1));
    step();
  endtask

  initial begin
    int base;
    int cyc;
    reset = 1'b1; start = 1'b1; in_valid = 1'b0; out_ready = 1'b0; input_bit = '0;
    start1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; input_bit1 = '0;
    #2;
    chk("rst_out_valid", FW'(out_valid), FW'(0));
    chk("rst_word_count", FW'(word_count), FW'(0));
    chk("rst_segments", segments_out, FW'(0));
    chk("rst_busy", FW'(busy), FW'(0));
    chk("rst_in_ready", FW'(in_ready), FW'(1));
    step(); step();
    reset = 1'b0;
    step();

    // Back-to-back frame with an always-ready consumer.
    out_ready = 1'b1;
    for (int i = 1; i <= NUM_SEG; i++) send(WIDTH'(i));
    in_valid = 1'b0;
    step(); step(); step();
    chk("idle_busy", FW'(busy), FW'(0));

    // Stalled consumer: frame 1 held, frame 2 fills behind it.
    out_ready = 1'b0;
    for (int i = 1; i <= 2 * NUM_SEG; i++) send(WIDTH'(i));
    in_valid = 1'b0;
    step(); step();
    chk("stall_word_count", FW'(word_count), FW'(NUM_SEG));
    chk("stall_in_ready", FW'(in_ready), FW'(0));
    chk("stall_seg0", FW'(segments_out[WIDTH-1:0]), FW'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("swap_out_valid", FW'(out_valid), FW'(1));
    chk("swap_seg0", FW'(segments_out[WIDTH-1:0]), FW'(11));
    chk("swap_in_ready", FW'(in_ready), FW'(1));
    out_ready = 1'b1;
    step(); step();

    // Abort a partial frame, then refill with fresh data.
    for (int i = 0; i < 4; i++) send(WIDTH'(32'h50 + i));
    in_valid = 1'b0;
    start = 1'b0;
    chk("pre_abort_count", FW'(word_count), FW'(4));
    step();
    chk("post_abort_count", FW'(word_count), FW'(0));
    start = 1'b1;
    for (int i = 0; i < NUM_SEG; i++) send(WIDTH'(32'hA0 + i));
    in_valid = 1'b0;
    step(); step(); step();

    // Random gaps, consumer back-pressure and occasional aborts over 50 frames.
    base = frames_done;
    cyc = 0;
    while (frames_done < base + 50 && cyc < 4000) begin
      in_valid  = ($urandom % 4) != 0;
      input_bit = $urandom;
      out_ready = ($urandom % 3) != 0;
      start     = ($urandom % 40) != 0;
      step();
      cyc++;
    end
    chk("random_frames_done", FW'(frames_done >= base + 50), FW'(1));
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    chk("scoreboard_drained", FW'(exp_q.size()), FW'(0));

    // Asynchronous reset with a held frame and a partially filled one.
    out_ready = 1'b0;
    for (int i = 0; i < NUM_SEG + 6; i++) send(WIDTH'(32'hC0 + i));
    in_valid = 1'b0;
    step();
    chk("pre_reset_count", FW'(word_count), FW'(6));
    chk("pre_reset_valid", FW'(out_valid), FW'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", FW'(out_valid), FW'(0));
    chk("async_word_count", FW'(word_count), FW'(0));
    chk("async_segments", segments_out, FW'(0));
    chk("async_busy", FW'(busy), FW'(0));
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step();

    // Single-segment instance: accept/transfer alternate every cycle.
    for (int c = 0; c < 8; c++) begin
      start1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
      input_bit1 = WIDTH'(c + 1);
      @(negedge clk);
      chk("ns1_in_ready", FW'(in_ready1), FW'(c % 2 == 0));
      chk("ns1_out_valid", FW'(out_valid1), FW'((c >= 2) && (c % 2 == 0)));
      if (c >= 2 && c % 2 == 0) chk("ns1_segment", FW'(segments_out1), FW'(c - 1));
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
